ll_data_table_dequeue_burst: RTL and testbench

LL_DATA_TABLE_DEQUEUE_BURST -- requirements
Module: ll_data_table_dequeue_burst

---
 rtl/linked_list.sv | 41 ++++
 rtl/ll_head_table_if.sv | 12 +
 rtl/ll_rd_data_val_helper.sv | 22 ++
 rtl/ll_data_table_dequeue_burst.sv | 141 ++++++++++++++
 tb/tb_ll_data_table_dequeue_burst.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/linked_list.sv
// linked_list: shared types for the linked-list hash table datapath
// Provides RAM entry, task, result and head-table types plus the dequeue FSM state encoding.
package linked_list;
  localparam int LL_TABLE_ADDR_WIDTH = 8;
  localparam int LL_KEY_WIDTH        = 16;
  localparam int LL_VALUE_WIDTH      = 16;
  typedef enum logic [1:0] {
    LL_OP_INSERT, LL_OP_DELETE, LL_OP_SEARCH, LL_OP_DEQUEUE
  } ll_opcode_t;
  typedef enum logic [2:0] {
    LL_SEARCH_FOUND, LL_SEARCH_NOT_FOUND, LL_INSERT_SUCCESS, LL_DELETE_SUCCESS,
    LL_DEQUEUE_SUCCESS, LL_DEQUEUE_NOT_SUCCESS_NO_ENTRY, LL_DEQUEUE_PARTIAL
  } ll_rescode_t;
  typedef enum logic [1:0] {
    LL_NO_CHAIN, LL_IN_HEAD, LL_IN_MIDDLE, LL_IN_TAIL
  } ll_chain_state_t;
  typedef struct packed {
    ll_opcode_t                opcode;
    logic [LL_KEY_WIDTH-1:0]   key;
    logic [LL_VALUE_WIDTH-1:0] value;
  } ll_cmd_t;
  typedef struct packed {
    ll_cmd_t                        cmd;
    logic [LL_TABLE_ADDR_WIDTH-1:0] head_ptr;
    logic                           head_ptr_val;
  } ll_ht_pdata_t;
  typedef struct packed {
    logic [LL_KEY_WIDTH-1:0]        key;
    logic [LL_VALUE_WIDTH-1:0]      value;
    logic [LL_TABLE_ADDR_WIDTH-1:0] next_ptr;
    logic                           next_ptr_val;
  } ll_ram_data_t;
  typedef struct packed {
    ll_cmd_t         cmd;
    ll_rescode_t     rescode;
    ll_chain_state_t chain_state;
  } ll_ht_result_t;
  typedef enum logic [2:0] {
    IDLE_S, NO_ENTRY_S, READ_S, CLEAR_S, UPDATE_HEAD_S, REPORT_S
  } ll_dq_state_t;
endpackage

// File: rtl/ll_head_table_if.sv
// ll_head_table_if: head pointer write port (master drives wr_data_ptr, wr_data_ptr_val, wr_en)
interface ll_head_table_if
  import linked_list::*;
#(
  parameter int A_WIDTH = LL_TABLE_ADDR_WIDTH
);
  logic [A_WIDTH-1:0] wr_data_ptr;
  logic               wr_data_ptr_val;
  logic               wr_en;
  modport master (output wr_data_ptr, output wr_data_ptr_val, output wr_en);
  modport slave  (input  wr_data_ptr, input  wr_data_ptr_val, input  wr_en);
endinterface

// File: rtl/ll_rd_data_val_helper.sv
// ll_rd_data_val_helper: delays the RAM read strobe by RAM_LATENCY cycles to flag valid read data
// Ports: clk_i, rst_n_i (async active-low), rd_en_i (read strobe), rd_data_val_o (data valid).
module ll_rd_data_val_helper #(
  parameter int RAM_LATENCY = 2
)(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic rd_en_i,
  output logic rd_data_val_o
);
  logic [RAM_LATENCY-1:0] sh_q;
  if (RAM_LATENCY == 1) begin : g_one
    always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) sh_q <= '0;
      else sh_q <= rd_en_i;
  end else begin : g_pipe
    always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) sh_q <= '0;
      else sh_q <= {sh_q[RAM_LATENCY-2:0], rd_en_i};
  end
  assign rd_data_val_o = sh_q[RAM_LATENCY-1];
endmodule

// File: rtl/ll_data_table_dequeue_burst.sv
// ll_data_table_dequeue_burst: pops up to MAX_BURST entries from a list head, clearing and freeing each
// Ports: task_* (request in), rd_*/wr_* (data RAM), add_empty_ptr_* (free list),
// ll_head_table_if (single head update per task), result_* (outcome handshake).
module ll_data_table_dequeue_burst
  import linked_list::*;
#(
  parameter  int RAM_LATENCY = 2,
  parameter  int A_WIDTH     = LL_TABLE_ADDR_WIDTH,
  parameter  int MAX_BURST   = 8,
  localparam int CNT_WIDTH   = $clog2(MAX_BURST + 1)
)(
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  ll_ht_pdata_t         task_i,
  input  logic [CNT_WIDTH-1:0] task_cnt_i,
  input  logic                 task_valid_i,
  output logic                 task_ready_o,
  input  ll_ram_data_t         rd_data_i,
  output logic [A_WIDTH-1:0]   rd_addr_o,
  output logic                 rd_en_o,
  output logic [A_WIDTH-1:0]   wr_addr_o,
  output ll_ram_data_t         wr_data_o,
  output logic                 wr_en_o,
  output logic [A_WIDTH-1:0]   add_empty_ptr_o,
  output logic                 add_empty_ptr_en_o,
  ll_head_table_if.master      ll_head_table_if,
  output ll_ht_result_t        result_o,
  output logic [CNT_WIDTH-1:0] result_cnt_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i
);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_BURST);
  ll_dq_state_t         state_q;
  ll_opcode_t           opcode_q;
  ll_ram_data_t         data_q;
  logic [CNT_WIDTH-1:0] req_q, done_q, req_d;
  logic [A_WIDTH-1:0]   cur_ptr_q;
  logic                 rd_en_q, wr_en_q, empty_en_q, head_wr_q, res_valid_q;
  logic                 rd_val, last_d;
  ll_ht_result_t        res;
  logic                 unused_task;
  assign unused_task = ^{task_i.cmd.key, task_i.cmd.value};
  ll_rd_data_val_helper #(.RAM_LATENCY(RAM_LATENCY)) u_rd_val (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .rd_en_i       (rd_en_q),
    .rd_data_val_o (rd_val)
  );
  assign req_d  = task_cnt_i > MAX_CNT ? MAX_CNT : task_cnt_i;
  // Stop on burst quota or when the entry just cleared was the list tail.
  assign last_d = (done_q + CNT_WIDTH'(1) == req_q) || !data_q.next_ptr_val;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q     <= IDLE_S;
      opcode_q    <= LL_OP_INSERT;
      data_q      <= '0;
      req_q       <= '0;
      done_q      <= '0;
      cur_ptr_q   <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      empty_en_q  <= 1'b0;
      head_wr_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE_S: if (task_valid_i) begin
          opcode_q  <= task_i.cmd.opcode;
          req_q     <= req_d;
          done_q    <= '0;
          data_q    <= '0;
          cur_ptr_q <= A_WIDTH'(task_i.head_ptr);
          if (!task_i.head_ptr_val) begin
            state_q     <= NO_ENTRY_S;
            res_valid_q <= 1'b1;
          end else if (req_d == '0) begin
            state_q     <= REPORT_S;
            res_valid_q <= 1'b1;
          end else begin
            state_q <= READ_S;
            rd_en_q <= 1'b1;
          end
        end
        READ_S: begin
          rd_en_q <= 1'b0;
          if (rd_val) begin
            data_q     <= rd_data_i;
            wr_en_q    <= 1'b1;
            empty_en_q <= 1'b1;
            state_q    <= CLEAR_S;
          end
        end
        CLEAR_S: begin
          wr_en_q    <= 1'b0;
          empty_en_q <= 1'b0;
          done_q     <= done_q + CNT_WIDTH'(1);
          if (last_d) begin
            head_wr_q <= 1'b1;
            state_q   <= UPDATE_HEAD_S;
          end else begin
            cur_ptr_q <= A_WIDTH'(data_q.next_ptr);
            rd_en_q   <= 1'b1;
            state_q   <= READ_S;
          end
        end
        UPDATE_HEAD_S: begin
          head_wr_q   <= 1'b0;
          res_valid_q <= 1'b1;
          state_q     <= REPORT_S;
        end
        REPORT_S, NO_ENTRY_S: if (result_ready_i) begin
          res_valid_q <= 1'b0;
          state_q     <= IDLE_S;
        end
        default: state_q <= IDLE_S;
      endcase
    end
  always_comb begin
    res             = '0;
    res.cmd.opcode  = opcode_q;
    res.cmd.key     = data_q.key;
    res.cmd.value   = data_q.value;
    res.rescode     = state_q == NO_ENTRY_S ? LL_DEQUEUE_NOT_SUCCESS_NO_ENTRY :
                      done_q < req_q ? LL_DEQUEUE_PARTIAL : LL_DEQUEUE_SUCCESS;
    res.chain_state = done_q == '0 ? LL_NO_CHAIN : LL_IN_HEAD;
  end
  assign task_ready_o       = state_q == IDLE_S;
  assign rd_en_o            = rd_en_q;
  assign rd_addr_o          = cur_ptr_q;
  assign wr_en_o            = wr_en_q;
  assign wr_addr_o          = cur_ptr_q;
  assign wr_data_o          = '0;
  assign add_empty_ptr_en_o = empty_en_q;
  assign add_empty_ptr_o    = cur_ptr_q;
  assign ll_head_table_if.wr_en           = head_wr_q;
  assign ll_head_table_if.wr_data_ptr     = A_WIDTH'(data_q.next_ptr);
  assign ll_head_table_if.wr_data_ptr_val = data_q.next_ptr_val;
  assign result_valid_o     = res_valid_q;
  assign result_o           = res_valid_q ? res : '0;
  assign result_cnt_o       = done_q;
endmodule

// File: tb/tb_ll_data_table_dequeue_burst.sv
// tb_ll_data_table_dequeue_burst: directed bench with a latency-2 RAM model and strobe monitor
module tb_ll_data_table_dequeue_burst;
  import linked_list::*;
  localparam int AW = 8;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ll_ht_pdata_t  task_i;
  logic [CW-1:0] task_cnt_i;
  logic          task_valid_i = 1'b0;
  logic          task_ready_o;
  ll_ram_data_t  rd_data_i, wr_data_o;
  logic [AW-1:0] rd_addr_o, wr_addr_o, add_empty_ptr_o;
  logic          rd_en_o, wr_en_o, add_empty_ptr_en_o;
  ll_ht_result_t result_o;
  logic [CW-1:0] result_cnt_o;
  logic          result_valid_o;
  logic          result_ready_i = 1'b0;
  ll_head_table_if #(.A_WIDTH(AW)) head_if ();
  ll_data_table_dequeue_burst #(.RAM_LATENCY(2), .A_WIDTH(AW), .MAX_BURST(8)) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .task_i             (task_i),
    .task_cnt_i         (task_cnt_i),
    .task_valid_i       (task_valid_i),
    .task_ready_o       (task_ready_o),
    .rd_data_i          (rd_data_i),
    .rd_addr_o          (rd_addr_o),
    .rd_en_o            (rd_en_o),
    .wr_addr_o          (wr_addr_o),
    .wr_data_o          (wr_data_o),
    .wr_en_o            (wr_en_o),
    .add_empty_ptr_o    (add_empty_ptr_o),
    .add_empty_ptr_en_o (add_empty_ptr_en_o),
    .ll_head_table_if   (head_if),
    .result_o           (result_o),
    .result_cnt_o       (result_cnt_o),
    .result_valid_o     (result_valid_o),
    .result_ready_i     (result_ready_i)
  );
  ll_ram_data_t mem [256];
  ll_ram_data_t p1, p2;
  logic         ld_en = 1'b0;
  logic [7:0]   ld_addr;
  ll_ram_data_t ld_data;
  assign rd_data_i = p2;
  always @(posedge clk) begin
    p1 <= mem[rd_addr_o];
    p2 <= p1;
    if (wr_en_o) mem[wr_addr_o] <= wr_data_o;
    else if (ld_en) mem[ld_addr] <= ld_data;
  end
  int n_rd = 0, n_head = 0, n_wrdat_bad = 0;
  int freed_q[$], clr_q[$];
  int head_ptr_seen = 0, head_val_seen = 0;
  always @(negedge clk) begin
    if (rd_en_o) n_rd++;
    if (wr_en_o) begin
      clr_q.push_back(int'(wr_addr_o));
      if (wr_data_o != '0) n_wrdat_bad++;
    end
    if (add_empty_ptr_en_o) freed_q.push_back(int'(add_empty_ptr_o));
    if (head_if.wr_en) begin
      n_head++;
      head_ptr_seen = int'(head_if.wr_data_ptr);
      head_val_seen = int'(head_if.wr_data_ptr_val);
    end
  end
  int n_tests = 0, n_fail = 0;
  int b_rd, b_head, b_free, b_clr, lat;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic load(input int a, input int nxt, input logic nv);
    ld_en   = 1'b1;
    ld_addr = 8'(a);
    ld_data.key          = 16'(32'h100 + a);
    ld_data.value        = 16'(32'h200 + a);
    ld_data.next_ptr     = 8'(nxt);
    ld_data.next_ptr_val = nv;
    @(negedge clk);
    ld_en = 1'b0;
  endtask
  task automatic drive_task(input int hp, input logic hv, input int cnt, input ll_opcode_t op);
    b_rd   = n_rd;
    b_head = n_head;
    b_free = freed_q.size();
    b_clr  = clr_q.size();
    chk("task_ready", task_ready_o, 1);
    task_i.cmd.opcode   = op;
    task_i.cmd.key      = 16'hBEEF;
    task_i.cmd.value    = 16'h1234;
    task_i.head_ptr     = 8'(hp);
    task_i.head_ptr_val = hv;
    task_cnt_i          = CW'(cnt);
    task_valid_i        = 1'b1;
    @(negedge clk);
    task_valid_i = 1'b0;
  endtask
  task automatic run_task(input int hp, input logic hv, input int cnt, input ll_opcode_t op);
    drive_task(hp, hv, cnt, op);
    lat = 0;
    while (!result_valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic check_res(input string t, input ll_rescode_t rc, input int cnt, input int key,
                           input ll_chain_state_t cs, input ll_opcode_t op, input int lat_exp,
                           input int nhead);
    chk({t, ".valid"},   result_valid_o, 1);
    chk({t, ".latency"}, lat, lat_exp);
    chk({t, ".rescode"}, result_o.rescode, rc);
    chk({t, ".cnt"},     result_cnt_o, cnt);
    chk({t, ".key"},     result_o.cmd.key, key);
    chk({t, ".chain"},   result_o.chain_state, cs);
    chk({t, ".opcode"},  result_o.cmd.opcode, op);
    chk({t, ".n_rd"},    n_rd - b_rd, cnt);
    chk({t, ".n_free"},  freed_q.size() - b_free, cnt);
    chk({t, ".n_clr"},   clr_q.size() - b_clr, cnt);
    chk({t, ".n_head"},  n_head - b_head, nhead);
  endtask
  task automatic check_freed(input string t, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      chk({t, ".freed"}, (b_free + i < freed_q.size()) ? freed_q[b_free + i] : -1, first + i * (first < 100 ? 10 : 1));
      chk({t, ".clr"},   (b_clr + i < clr_q.size()) ? clr_q[b_clr + i] : -1, first + i * (first < 100 ? 10 : 1));
    end
  endtask
  task automatic finish_result(input int hold);
    ll_ht_result_t r = result_o;
    logic [CW-1:0] c = result_cnt_o;
    repeat (hold) begin
      @(negedge clk);
      chk("hold.valid",  result_valid_o, 1);
      chk("hold.stable", (result_o == r) && (result_cnt_o == c), 1);
      chk("hold.ready",  task_ready_o, 0);
    end
    result_ready_i = 1'b1;
    @(negedge clk);
    result_ready_i = 1'b0;
    chk("result.drop", result_valid_o, 0);
  endtask
  initial begin
    int seen;
    task_i     = '0;
    task_cnt_i = '0;
    repeat (2) @(negedge clk);
    chk("rst.task_ready", task_ready_o, 1);
    chk("rst.valid",      result_valid_o, 0);
    chk("rst.cnt",        result_cnt_o, 0);
    chk("rst.result",     result_o, 0);
    chk("rst.strobes",    {rd_en_o, wr_en_o, add_empty_ptr_en_o, head_if.wr_en}, 0);
    load(10, 20, 1'b1);
    load(20, 30, 1'b1);
    load(30, 0, 1'b0);
    load(40, 50, 1'b1);
    load(50, 0, 1'b0);
    for (int i = 100; i < 110; i++) load(i, i + 1, i != 109);
    load(200, 201, 1'b1);
    load(201, 202, 1'b1);
    load(202, 0, 1'b0);
    rst_n = 1'b1;
    run_task(10, 1'b1, 2, LL_OP_DEQUEUE);
    check_res("t1", LL_DEQUEUE_SUCCESS, 2, 16'h114, LL_IN_HEAD, LL_OP_DEQUEUE, 9, 1);
    check_freed("t1", 10, 2);
    chk("t1.head_ptr", head_ptr_seen, 30);
    chk("t1.head_val", head_val_seen, 1);
    chk("t1.mem10",    mem[10], 0);
    chk("t1.mem30",    mem[30].key, 16'h11E);
    finish_result(0);
    run_task(40, 1'b1, 5, LL_OP_DEQUEUE);
    check_res("t2", LL_DEQUEUE_PARTIAL, 2, 16'h132, LL_IN_HEAD, LL_OP_DEQUEUE, 9, 1);
    check_freed("t2", 40, 2);
    chk("t2.head_val", head_val_seen, 0);
    finish_result(0);
    run_task(77, 1'b0, 3, LL_OP_SEARCH);
    check_res("t3", LL_DEQUEUE_NOT_SUCCESS_NO_ENTRY, 0, 0, LL_NO_CHAIN, LL_OP_SEARCH, 0, 0);
    finish_result(0);
    run_task(100, 1'b1, 0, LL_OP_DEQUEUE);
    check_res("t4", LL_DEQUEUE_SUCCESS, 0, 0, LL_NO_CHAIN, LL_OP_DEQUEUE, 0, 0);
    finish_result(0);
    run_task(100, 1'b1, 15, LL_OP_DEQUEUE);
    check_res("t5", LL_DEQUEUE_SUCCESS, 8, 16'h16B, LL_IN_HEAD, LL_OP_DEQUEUE, 33, 1);
    check_freed("t5", 100, 8);
    chk("t5.head_ptr", head_ptr_seen, 108);
    chk("t5.head_val", head_val_seen, 1);
    chk("t5.mem108",   mem[108].key, 16'h16C);
    finish_result(4);
    drive_task(200, 1'b1, 3, LL_OP_DEQUEUE);
    seen = 0;
    lat  = 0;
    while (seen < 2 && lat < 50) begin
      if (rd_en_o) seen++;
      if (seen < 2) begin
        @(negedge clk);
        lat++;
      end
    end
    chk("t6.second_read", seen, 2);
    rst_n = 1'b0;
    #1;
    chk("t6.strobes", {rd_en_o, wr_en_o, add_empty_ptr_en_o, head_if.wr_en}, 0);
    chk("t6.valid",   result_valid_o, 0);
    chk("t6.cnt",     result_cnt_o, 0);
    chk("t6.result",  result_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6.no_head", n_head - b_head, 0);
    chk("t6.mem200",  mem[200], 0);
    run_task(201, 1'b1, 1, LL_OP_DEQUEUE);
    check_res("t7", LL_DEQUEUE_SUCCESS, 1, 16'h1C9, LL_IN_HEAD, LL_OP_DEQUEUE, 5, 1);
    chk("t7.head_ptr", head_ptr_seen, 202);
    finish_result(0);
    chk("wr_data_zero", n_wrdat_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end
endmodule
